// File: rtl/rom_sample_sequencer.sv
// Sequences nibble reads from a 1024x4 synchronous ROM, packs pairs into bytes
// and broadcasts each byte to the LPF and HPF consumers with a one-deep prefetch.
module rom_sample_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int NIBBLES  = 1024,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rom_cen,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [3:0]        rom_q,
  output logic [7:0]        x,
  output logic              x_valid,
  input  logic              lpf_ready,
  input  logic              hpf_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP,
    WAIT,
    DRAIN
  } state_e;

  localparam logic [ADDR_W:0] END_A = NIBBLES[ADDR_W:0];
  localparam logic [ADDR_W:0] A_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [3:0]        nib_q, nib_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [7:0]        x_q, x_d;
  logic              x_valid_q, x_valid_d;
  logic              lpf_tk_q, lpf_tk_d;
  logic              hpf_tk_q, hpf_tk_d;
  logic              rom_cen_q, rom_cen_d;
  logic [ADDR_W-1:0] rom_a_q, rom_a_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              retire;
  logic              rd;
  logic [7:0]        sample;

  assign sample = HI_FIRST ? {nib_q, rom_q} : {rom_q, nib_q};
  assign retire = x_valid_q
                & (lpf_tk_q | lpf_ready)
                & (hpf_tk_q | hpf_ready);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    nib_d      = nib_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    x_d        = x_q;
    x_valid_d  = x_valid_q;
    lpf_tk_d   = lpf_tk_q;
    hpf_tk_d   = hpf_tk_q;
    done_d     = 1'b0;

    if (retire) begin
      lpf_tk_d   = 1'b0;
      hpf_tk_d   = 1'b0;
      x_valid_d  = buf_full_q;
      buf_full_d = 1'b0;
      if (buf_full_q) begin
        x_d = buf_q;
      end
    end else if (x_valid_q) begin
      lpf_tk_d = lpf_tk_q | lpf_ready;
      hpf_tk_d = hpf_tk_q | hpf_ready;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_A;
          addr_d  = '0;
        end
      end
      RD_A: begin
        state_d = RD_B;
        addr_d  = addr_q + A_ONE;
      end
      RD_B: begin
        nib_d   = rom_q;
        state_d = CAP;
      end
      CAP: begin
        // x_valid_d already reflects this cycle's retire/reload
        if (!x_valid_d) begin
          x_d       = sample;
          x_valid_d = 1'b1;
        end else begin
          buf_d      = sample;
          buf_full_d = 1'b1;
        end
        addr_d = addr_q + A_ONE;
        if (addr_d == END_A) begin
          state_d = DRAIN;
        end else if (buf_full_d) begin
          state_d = WAIT;
        end else begin
          state_d = RD_A;
        end
      end
      WAIT: begin
        if (!buf_full_d) begin
          state_d = RD_A;
        end
      end
      DRAIN: begin
        if (!x_valid_q && !buf_full_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ROM pins are registered from the next state so they line up with RD_A/RD_B
  always_comb begin
    rd        = (state_d == RD_A) || (state_d == RD_B);
    rom_cen_d = ~rd;
    rom_a_d   = rd ? addr_d[ADDR_W-1:0] : rom_a_q;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      nib_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      x_q        <= '0;
      x_valid_q  <= 1'b0;
      lpf_tk_q   <= 1'b0;
      hpf_tk_q   <= 1'b0;
      rom_cen_q  <= 1'b1;
      rom_a_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      nib_q      <= nib_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      x_q        <= x_d;
      x_valid_q  <= x_valid_d;
      lpf_tk_q   <= lpf_tk_d;
      hpf_tk_q   <= hpf_tk_d;
      rom_cen_q  <= rom_cen_d;
      rom_a_q    <= rom_a_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_cen = rom_cen_q;
  assign rom_a   = rom_a_q;
  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/rom_sample_sequencer.md
Name: rom_sample_sequencer

Overview:
- Sequences reads of the 1024x4 synchronous coefficient/sample ROM (active-low CEN, one-cycle read latency).
- Assembles consecutive nibble pairs into 8-bit samples and broadcasts each sample to the LPF and HPF consumers with a per-consumer valid/ready handshake.
- Replaces ad-hoc divided-clock ROM gating in the filter top level: it runs on the single system clock and prefetches one sample ahead.

Parameters:
- ADDR_W, 10, ROM address width.
- NIBBLES, 1024, number of ROM words read per run; must be even.
- HI_FIRST, 1, 1: even address = sample[7:4]; 0: even address = sample[3:0].

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run from address 0 when idle.
- rom_cen  output  1  ROM chip enable, active-low.
- rom_a  output  ADDR_W  ROM address.
- rom_q  input  4  ROM data, valid the cycle after an enabled address edge.
- x  output  8  broadcast sample.
- x_valid  output  1  x holds an unretired sample.
- lpf_ready  input  1  LPF accepts x this cycle.
- hpf_ready  input  1  HPF accepts x this cycle.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse after the last sample is retired.

Behaviour:
- Reset (reset=0, async): all outputs are driven as follows.
  - rom_cen=1, rom_a=0, x=0, x_valid=0, busy=0, done=0.
  - Address counter, nibble latch, prefetch buffer and taken flags are cleared.
  - FSM enters IDLE.
- FSM states: IDLE, RD_A, RD_B, CAP, WAIT, DRAIN.
  - IDLE: rom_cen=1. On start, go to RD_A with addr=0 and set busy=1. start is ignored outside IDLE.
  - RD_A: rom_cen=0, rom_a=addr (even address). Next state is RD_B with addr+1.
  - RD_B: rom_cen=0, rom_a=addr (odd address). rom_q now holds the even nibble; latch it. Next state is CAP.
  - CAP: rom_cen=1. rom_q holds the odd nibble. Form the sample per HI_FIRST:
    - If the output register is free (x_valid=0, or retiring this cycle), load x and set x_valid next cycle.
    - Otherwise write the sample into the prefetch buffer.
    - Increment addr. If addr wraps past NIBBLES-1, go to DRAIN; else go to RD_A if the prefetch buffer is free, else WAIT.
  - WAIT: rom_cen=1. When the buffer empties, go to RD_A.
  - DRAIN: rom_cen=1. When x_valid=0 and the buffer is empty, pulse done, clear busy and go to IDLE.
- Nibble-to-sample latency: x_valid rises 3 cycles after entering RD_A when the output register is free. Steady-state throughput is one sample per 3 cycles if both consumers are always ready.
- Broadcast handshake:
  - Per-consumer taken flags lpf_tk and hpf_tk.
  - A consumer's transfer occurs when x_valid & ready & ~taken; its taken flag sets.
  - The sample retires in the cycle where both consumers have transferred, counting the current cycle: (lpf_tk|lpf_ready)&(hpf_tk|hpf_ready).
  - On retire, both flags clear. x and x_valid reload from the prefetch buffer if it is full; otherwise x_valid=0.
  - x is held stable while x_valid=1 and unretired. A consumer asserting ready after it has already taken the sample has no effect.
- Simultaneous events:
  - Retire and CAP in the same cycle: the new sample goes directly to x if the buffer is empty. If the buffer is full, the buffer moves to x and the new sample goes into the buffer. No sample is lost or duplicated.
- Address wrap: rom_a never exceeds NIBBLES-1. The counter is ADDR_W+1 bits wide internally, and the terminal condition is addr==NIBBLES.
- Reset mid-run: immediate abort to IDLE. done is not pulsed, and any buffered sample is discarded.
- ROM addressing: rom_a is registered. rom_cen=0 only in RD_A and RD_B. rom_a holds its last value when rom_cen=1.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles then release, no start -> rom_cen=1, x_valid=0, busy=0, done=0 indefinitely.
- Basic run: ROM[0]=0xA, ROM[1]=0x5, both readys held at 1, HI_FIRST=1 -> first x=0xA5, x_valid rises 3 cycles after RD_A. A sample retires every 3 cycles, giving 512 samples. done pulses once after the last sample, then busy=0.
- Split acceptance: LPF ready at cycle t, HPF ready at t+4 -> x stable from t to t+4. Retire occurs at t+4. Prefetch buffer fills and the FSM sits in WAIT (rom_cen=1), then resumes RD_A after the buffer moves to x.
- Same-cycle retire and CAP with the buffer full -> the output sequence equals the ROM pair order exactly, with no gap or duplicate. Checked by scoreboard over the full run with random ready patterns.
- Wrap and restart: NIBBLES=8, start asserted while busy is ignored. After done, a second start reads again from address 0 -> rom_a sequence is 0..7 twice, with max rom_a=7.
- Mid-run reset: pull reset low during CAP of sample 100 -> outputs go to reset values immediately and done stays 0. A new start yields a first x equal to the ROM[0]/ROM[1] pair.
